an_encoder_err_inj: RTL and testbench



---
 rtl/an_encoder_err_inj_if.sv | 32 +++
 rtl/an_encoder_err_inj.sv | 123 ++++++++++++
 tb/tb_an_encoder_err_inj.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/an_encoder_err_inj_if.sv
// an_encoder_err_inj_if
// Handshake bundle between an encoder source and the AN-code encoder.
//   in_valid/in_ready : request channel carrying N_in, e1, e2
//   out_valid/out_ready : codeword channel carrying W_out, AN_out, clip, wrap
// master = request producer / codeword consumer, slave = encoder.
interface an_encoder_err_inj_if #(
  parameter int N_BITS = 21,
  parameter int W_BITS = 34,
  parameter int L_BITS = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_BITS-1:0]        N_in;
  logic signed [L_BITS:0]   e1;
  logic signed [L_BITS:0]   e2;
  logic                     out_valid;
  logic                     out_ready;
  logic [W_BITS-1:0]        W_out;
  logic [W_BITS-1:0]        AN_out;
  logic                     clip;
  logic                     wrap;

  modport master (
    output in_valid, N_in, e1, e2, out_ready,
    input  in_ready, out_valid, W_out, AN_out, clip, wrap
  );

  modport slave (
    input  in_valid, N_in, e1, e2, out_ready,
    output in_ready, out_valid, W_out, AN_out, clip, wrap
  );
endinterface

// File: rtl/an_encoder_err_inj.sv
// an_encoder_err_inj
// Encodes a data word N as W = A*N with a 13-step shift-add multiplier, then
// optionally adds up to two signed errors of +/-2^(|e|-1) before handing the
// codeword to the decoder.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : an_encoder_err_inj_if.slave (request in, codeword out)
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// MUL   | one multiplier bit of A per cycle, 13 cycles
// INJ   | apply error contributions, register outputs
// HOLD  | out_valid high, outputs frozen until out_ready
module an_encoder_err_inj #(
  parameter int A      = 6311,
  parameter int A_BITS = 13,
  parameter int N_BITS = 21,
  parameter int W_BITS = 34,
  parameter int L_BITS = 6,
  parameter int L_MAX  = 33
) (
  input logic                clk,
  input logic                rst_n,
  an_encoder_err_inj_if.slave bus
);

  // Signed sum needs two extra bits: range is -2^33 .. 2^34 + 2^33.
  localparam int S_BITS = W_BITS + 2;
  localparam int C_BITS = $clog2(A_BITS);
  localparam logic [A_BITS-1:0] A_VEC   = A_BITS'(A);
  localparam logic [L_BITS:0]   L_MAX_V = (L_BITS+1)'(L_MAX);
  localparam logic [C_BITS-1:0] CNT_END = C_BITS'(A_BITS - 1);

  typedef enum logic [1:0] {IDLE, MUL, INJ, HOLD} state_t;

  state_t                   state;
  logic [C_BITS-1:0]        cnt;
  logic [W_BITS-1:0]        acc;
  logic [W_BITS-1:0]        n_q;
  logic signed [L_BITS:0]   e1_q;
  logic signed [L_BITS:0]   e2_q;
  logic signed [S_BITS-1:0] inj_sum;
  logic                     inj_clip;

  // |e| as an unsigned value; -64 maps to 64 so it falls into the clip range.
  function automatic logic [L_BITS:0] loc_mag(input logic signed [L_BITS:0] e);
    logic [L_BITS:0] u;
    u = e;
    return u[L_BITS] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic loc_clip(input logic signed [L_BITS:0] e);
    return loc_mag(e) > L_MAX_V;
  endfunction

  function automatic logic signed [S_BITS-1:0] loc_contrib(input logic signed [L_BITS:0] e);
    logic [L_BITS:0]          mag;
    logic signed [S_BITS-1:0] pow;
    mag = loc_mag(e);
    if (mag == '0 || mag > L_MAX_V) return '0;
    pow = S_BITS'(1) << (mag - 1'b1);
    return e[L_BITS] ? -pow : pow;
  endfunction

  assign inj_sum  = $signed({2'b00, acc}) + loc_contrib(e1_q) + loc_contrib(e2_q);
  assign inj_clip = loc_clip(e1_q) | loc_clip(e2_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      n_q           <= '0;
      e1_q          <= '0;
      e2_q          <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.W_out     <= '0;
      bus.AN_out    <= '0;
      bus.clip      <= 1'b0;
      bus.wrap      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            n_q          <= W_BITS'(bus.N_in);
            e1_q         <= bus.e1;
            e2_q         <= bus.e2;
            acc          <= '0;
            cnt          <= '0;
            bus.clip     <= 1'b0;
            bus.wrap     <= 1'b0;
            bus.in_ready <= 1'b0;
            state        <= MUL;
          end
        end
        MUL: begin
          if (A_VEC[cnt]) acc <= acc + (n_q << cnt);
          cnt <= cnt + 1'b1;
          if (cnt == CNT_END) state <= INJ;
        end
        INJ: begin
          bus.W_out     <= inj_sum[W_BITS-1:0];
          bus.wrap      <= |inj_sum[S_BITS-1:W_BITS];
          bus.clip      <= inj_clip;
          bus.AN_out    <= acc;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_an_encoder_err_inj.sv
module tb_an_encoder_err_inj;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  an_encoder_err_inj_if #(.N_BITS(21), .W_BITS(34), .L_BITS(6)) bus ();

  an_encoder_err_inj dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Send one word, measure latency (accepting edge counts as edge 1), check
  // results, optionally hold out_ready low with ignored in_valid pulses, then
  // complete the handshake.
  task automatic run_word(input string tag, input logic [20:0] n,
                          input logic signed [6:0] a, input logic signed [6:0] b,
                          input logic [33:0] exp_w, input logic [33:0] exp_an,
                          input logic exp_clip, input logic exp_wrap,
                          input int hold);
    int edges;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.N_in     = n;
    bus.e1       = a;
    bus.e2       = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.N_in     = 21'h15555;
    bus.e1       = 7'sd7;
    bus.e2       = -7'sd9;
    edges = 1;
    while (!bus.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, ".latency"}, 64'(edges), 64'd15);
    chk({tag, ".W_out"},  64'(bus.W_out),  64'(exp_w));
    chk({tag, ".AN_out"}, 64'(bus.AN_out), 64'(exp_an));
    chk({tag, ".clip"},   64'(bus.clip),   64'(exp_clip));
    chk({tag, ".wrap"},   64'(bus.wrap),   64'(exp_wrap));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      chk({tag, ".hold_W"},        64'(bus.W_out),     64'(exp_w));
      chk({tag, ".hold_in_ready"}, 64'(bus.in_ready),  64'd0);
      chk({tag, ".hold_valid"},    64'(bus.out_valid), 64'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".post_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".post_ready"}, 64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.N_in      = '0;
    bus.e1        = '0;
    bus.e2        = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.W_out",     64'(bus.W_out),     64'd0);
    chk("rst.AN_out",    64'(bus.AN_out),    64'd0);
    chk("rst.clip",      64'(bus.clip),      64'd0);
    chk("rst.wrap",      64'(bus.wrap),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_word("zero",   21'd0,       7'sd0,   7'sd0,  34'd0,           34'd0,           1'b0, 1'b0, 0);
    run_word("one",    21'd1,       7'sd0,   7'sd0,  34'd6311,        34'd6311,        1'b0, 1'b0, 0);
    run_word("k1000",  21'd1000,    7'sd5,  -7'sd3,  34'd6311012,     34'd6311000,     1'b0, 1'b0, 5);
    run_word("maxwrap",21'd2097151, 7'sd33,  7'sd0,  34'd350218073,   34'd13235119961, 1'b0, 1'b1, 0);
    run_word("clip40", 21'd7,       7'sd40, -7'sd1,  34'd44176,       34'd44177,       1'b1, 1'b0, 0);
    run_word("dup",    21'd1,       7'sd1,   7'sd1,  34'd6313,        34'd6311,        1'b0, 1'b0, 0);
    run_word("negwrap",21'd0,      -7'sd1,   7'sd0,  34'd17179869183, 34'd0,           1'b0, 1'b1, 0);
    run_word("clipm64",21'd5,      -7'sd64,  7'sd34, 34'd31555,       34'd31555,       1'b1, 1'b0, 0);
    run_word("neg33",  21'd2097151,-7'sd33,  7'sd0,  34'd8940152665,  34'd13235119961, 1'b0, 1'b0, 0);

    // Reset in the middle of MUL: nothing may come out.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.N_in     = 21'd1000;
    bus.e1       = 7'sd5;
    bus.e2       = 7'sd0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst.W_out",     64'(bus.W_out),     64'd0);
    chk("midrst.AN_out",    64'(bus.AN_out),    64'd0);
    chk("midrst.clip",      64'(bus.clip),      64'd0);
    chk("midrst.wrap",      64'(bus.wrap),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst.no_output", 64'(seen), 64'd0);

    run_word("afterrst", 21'd3, 7'sd2, 7'sd0, 34'd18935, 34'd18933, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
